// File: rtl/ws2812_frame_serializer.sv
// WS2812 single-wire serializer.
// Captures a full GRB frame on a start edge. Shifts it out MSB first with
// WS2812 high/low bit timing, then holds the line low for the latch gap.
module ws2812_frame_serializer #(
  parameter int NUM_LEDS = 5,
  parameter int T_BIT    = 125,
  parameter int T0H      = 40,
  parameter int T1H      = 80,
  parameter int T_RST    = 6000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [24*NUM_LEDS-1:0]  frame_in,
  input  logic                    start,
  output logic                    dout,
  output logic                    busy,
  output logic                    done
);

  localparam int FRAME_W = 24 * NUM_LEDS;
  localparam int BIT_CW  = $clog2(FRAME_W + 1);
  localparam int CYC_MAX = (T_BIT > T_RST) ? T_BIT : T_RST;
  localparam int CYC_CW  = $clog2(CYC_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   sr_q, sr_d;
  logic [BIT_CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CYC_CW-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic                 dout_q, dout_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 start_q;
  logic                 armed_q;
  logic                 start_edge;

  // High time of the bit currently at the head of the shift register.
  function automatic logic [CYC_CW-1:0] high_len(input logic bit_val);
    return bit_val ? CYC_CW'(T1H) : CYC_CW'(T0H);
  endfunction

  // armed_q blocks the first cycle after reset. A start level held across
  // reset release is loaded into start_q first, so it is not seen as an edge.
  assign start_edge = start & ~start_q & armed_q;

  // Control registers: FSM state, counters, start history and the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start_q   <= start;
      armed_q   <= 1'b1;
    end
  end

  // Frame shift register. It holds data only, so it is not reset.
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  // Next-state logic. dout_d is the line level for the cycle that follows,
  // so a '0' or '1' pulse covers exactly T0H or T1H cycles of each bit.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    dout_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          sr_d      = frame_in;
          bit_cnt_d = '0;
          cyc_cnt_d = '0;
          state_d   = SEND;
          busy_d    = 1'b1;
          dout_d    = 1'b1;
        end
      end
      SEND: begin
        if (cyc_cnt_q == CYC_CW'(T_BIT - 1)) begin
          cyc_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_CW'(FRAME_W - 1)) begin
            state_d = LATCH;
            dout_d  = 1'b0;
          end else begin
            sr_d   = {sr_q[FRAME_W-2:0], 1'b0};
            dout_d = 1'b1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
          dout_d    = ((cyc_cnt_q + 1'b1) < high_len(sr_q[FRAME_W-1]));
        end
      end
      LATCH: begin
        if (cyc_cnt_q == CYC_CW'(T_RST - 1)) begin
          cyc_cnt_d = '0;
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
